// File: rtl/tdm_pkg.sv
// Shared TDM framing constants and receive FSM states.
package tdm_pkg;
  localparam int unsigned NCH    = 8;
  localparam int unsigned SLOT_W = 3;

  typedef enum logic {
    IDLE,
    COLLECT
  } tdm_state_e;
endpackage

// File: rtl/tdm_frame_buf.sv
// One-deep valid/ready frame holding register; a frame arriving while full and stalled is dropped.
module tdm_frame_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          overflow
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    overflow_d = 1'b0;
    if (load_valid) begin
      // Reload in the accept cycle keeps back-to-back frames bubble-free.
      if (!valid_q || out_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/tdm_demux_8.sv
// 8-slot TDM receiver: steers each beat into its channel slot and hands complete frames to a one-deep buffer.
module tdm_demux_8
  import tdm_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [W-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*W-1:0]   out_data,
  output logic [SLOT_W-1:0]  slot,
  output logic               sync_err,
  output logic               overflow
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCH - 1);

  tdm_state_e              state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  // Slot 7 is never stored: it completes the frame directly from in_data.
  logic [(NCH-1)*W-1:0]    shadow_q, shadow_d;
  logic                    sync_err_q, sync_err_d;
  logic                    frame_done;
  logic [NCH*W-1:0]        frame;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow_d   = shadow_q;
    sync_err_d = 1'b0;
    frame_done = 1'b0;
    frame      = {in_data, shadow_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            shadow_d[0 +: W] = in_data;
            slot_d           = SLOT_W'(1);
            state_d          = COLLECT;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (in_sof) begin
            sync_err_d       = 1'b1;
            shadow_d[0 +: W] = in_data;
            slot_d           = SLOT_W'(1);
          end else if (slot_q == LAST_SLOT) begin
            frame_done = 1'b1;
            slot_d     = '0;
            state_d    = IDLE;
          end else begin
            shadow_d[int'(slot_q)*W +: W] = in_data;
            slot_d                        = slot_q + SLOT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      shadow_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      shadow_q   <= shadow_d;
      sync_err_q <= sync_err_d;
    end
  end

  tdm_frame_buf #(
    .DW(NCH*W)
  ) u_frame_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(frame_done),
    .load_data (frame),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  assign slot     = slot_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed bench for tdm_demux_8 with a frame scoreboard drained by a handshake monitor.
module tb_tdm_demux_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_sof;
  logic [0:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] slot;
  logic       sync_err;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  tdm_demux_8 #(
    .W(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .slot     (slot),
    .sync_err (sync_err),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frames are consumed on the next rising edge when valid&ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(out_valid), 32'd0);
      end else begin
        check("frame_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic beat(input logic sof, input logic d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] f, input logic push);
    for (int unsigned k = 0; k < 8; k++) beat(k == 0, f[k]);
    if (push) exp_q.push_back(f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] clean;
    clean     = 8'b0100_1101;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean frame: latency of exactly one clock after the eighth beat
    for (int unsigned k = 0; k < 7; k++) beat(k == 0, clean[k]);
    check("clean_slot7", 32'(slot), 32'd7);
    check("clean_not_early", 32'(out_valid), 32'd0);
    beat(1'b0, clean[7]);
    exp_q.push_back(clean);
    check("clean_valid", 32'(out_valid), 32'd1);
    check("clean_slot_wrap", 32'(slot), 32'd0);
    check("clean_sync_err", 32'(sync_err), 32'd0);
    check("clean_overflow", 32'(overflow), 32'd0);
    idle(1);
    check("clean_valid_drop", 32'(out_valid), 32'd0);

    // Gapped frame
    for (int unsigned k = 0; k < 4; k++) beat(k == 0, clean[k]);
    for (int unsigned g = 0; g < 3; g++) begin
      idle(1);
      check("gap_slot_hold", 32'(slot), 32'd4);
    end
    for (int unsigned k = 4; k < 8; k++) beat(1'b0, clean[k]);
    exp_q.push_back(clean);
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_sync_err", 32'(sync_err), 32'd0);
    idle(1);

    // Early sof at slot 5
    for (int unsigned k = 0; k < 5; k++) beat(k == 0, 1'b1);
    check("early_slot5", 32'(slot), 32'd5);
    beat(1'b1, 1'b0);
    check("early_sync_err", 32'(sync_err), 32'd1);
    check("early_slot1", 32'(slot), 32'd1);
    beat(1'b0, 1'b1);
    check("early_sync_err_pulse", 32'(sync_err), 32'd0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    exp_q.push_back(8'h96);
    check("early_valid", 32'(out_valid), 32'd1);
    idle(1);

    // Missing sof in IDLE
    beat(1'b0, 1'b1);
    check("nosof_sync_err", 32'(sync_err), 32'd1);
    check("nosof_slot", 32'(slot), 32'd0);
    idle(1);
    check("nosof_no_frame", 32'(out_valid), 32'd0);
    check("nosof_pulse_end", 32'(sync_err), 32'd0);

    // Backpressure: second frame dropped while first is stalled
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data1", 32'(out_data), 32'hA5);
    check("bp_no_ovf_first", 32'(overflow), 32'd0);
    send_frame(8'h3C, 1'b0);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_data_held", 32'(out_data), 32'hA5);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    idle(1);
    check("bp_overflow_pulse", 32'(overflow), 32'd0);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_data_kept", 32'(out_data), 32'hA5);

    // Reset mid-frame while a frame is buffered
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    check("rmf_valid", 32'(out_valid), 32'd1);
    for (int unsigned k = 0; k < 5; k++) beat(k == 0, 1'b1);
    check("rmf_slot5", 32'(slot), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmf_out_valid", 32'(out_valid), 32'd0);
    check("rmf_out_data", 32'(out_data), 32'd0);
    check("rmf_slot", 32'(slot), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(clean, 1'b1);
    check("rmf_clean_valid", 32'(out_valid), 32'd1);
    check("rmf_clean_data", 32'(out_data), 32'(clean));
    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8.md
Name: tdm_demux_8

Overview:
- Receive-side counterpart of the team's 8:1 channel multiplexer.
- Accepts a time-division-multiplexed stream of one W-bit sample per beat, where slot k carries channel k.
- Steers each beat into its channel slot and publishes the assembled 8-channel frame through a one-deep valid/ready output buffer.
- Sits between the serial link and the per-channel consumers.

Parameters:
NCH, 8, number of channels per frame (fixed 8; slot counter is 3 bits)
W, 1, bits per channel sample

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat qualifier
in_sof  input  1  start-of-frame; marks the slot-0 beat, only meaningful with in_valid
in_data  input  W  sample for current slot
out_valid  output  1  frame buffer holds an unconsumed frame
out_ready  input  1  consumer accepts frame when out_valid&out_ready
out_data  output  NCH*W  frame; channel k at bits [k*W +: W]
slot  output  3  next expected slot index (0 in IDLE)
sync_err  output  1  one-cycle pulse on framing error
overflow  output  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, slot=0, shadow=0.
  - out_valid=0, out_data=0, sync_err=0, overflow=0.
- States: IDLE (hunting for sof), COLLECT (slots 1..7 pending).
- IDLE:
  - in_valid&in_sof: shadow[0]<=in_data, slot<=1, go COLLECT.
  - in_valid&!in_sof: beat discarded, sync_err pulse, stay IDLE.
  - !in_valid: hold.
- COLLECT:
  - in_valid&!in_sof: shadow[slot]<=in_data, slot<=slot+1.
  - At slot==7 the beat completes the frame: frame={in_data,shadow[6:0]}; slot wraps to 0; go IDLE.
  - in_valid&in_sof: partial frame discarded, sync_err pulse; beat taken as new slot 0, slot<=1, stay COLLECT.
  - !in_valid: hold; gaps of any length allowed mid-frame.
- Frame completion and output buffer:
  - Registered; out_valid rises the cycle after the 8th beat. Latency 1 clk from the final beat.
  - Completion with (!out_valid | out_ready): out_data<=frame, out_valid<=1. Simultaneous accept and reload gives back-to-back frames with no bubble.
  - Completion with out_valid&!out_ready: new frame dropped, overflow pulse; out_data is held unchanged.
  - Accept without completion: out_valid<=0; out_data keeps its last value.
- out_data stays stable while out_valid&!out_ready.
- Reset mid-frame: partial frame and buffered frame both lost; all outputs return to reset values immediately (async).
- sync_err and overflow are registered one-cycle pulses. Both can assert in the same cycle.
- Minimum frame: 8 consecutive in_valid beats gives one frame per 8 clocks. The output buffer always keeps up with this rate if out_ready is held high.

Decomposition:
- Shared package (tdm_pkg): constants NCH=8, SLOT_W=3, state enum {IDLE, COLLECT}.
  - The same constants are reused by the transmit-side frame serializer.
- One natural sub-module: tdm_frame_buf. It is the one-deep valid/ready holding register with the drop/overflow logic.
- The top level holds the slot counter, FSM and shadow register.

Test Plan:
- Clean frame, W=1:
  - Stimulus: in_sof on the first beat, 8 consecutive beats carrying bits 1,0,1,1,0,0,1,0 for slots 0..7; out_ready=1.
  - Required: out_valid high exactly 1 cycle after the 8th beat, out_data=8'b0100_1101; sync_err and overflow stay 0.
- Gapped frame:
  - Stimulus: same data with in_valid deasserted for 3 cycles after slot 3.
  - Required: identical out_data; slot holds at 4 during the gap.
- Early sof:
  - Stimulus: sof at slot 5 of a partial frame.
  - Required: sync_err pulse in that cycle; slot=1 afterwards; the next completed frame contains only the post-sof beats.
- Missing sof:
  - Stimulus: in_valid beat in IDLE without in_sof.
  - Required: sync_err pulse, slot stays 0, no frame produced.
- Backpressure:
  - Stimulus: out_ready=0, two complete frames 0xA5 then 0x3C.
  - Required: out_data stays 0xA5, overflow pulses once at the 2nd completion; after out_ready=1, out_valid drops next cycle.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after slot 4 while out_valid=1.
  - Required: out_valid=0, out_data=0, slot=0 immediately; a following clean frame decodes correctly.
